// File: rtl/generator_arbiter.sv
// generator_arbiter: round-robin front end sharing one generated generator
// among N requesters; routes yields back to the owner, releases on done.
module generator_arbiter #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                _clock,
  input  logic                _reset_n,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      arg,
  output logic [N-1:0]        grant,
  output logic [N-1:0]        rsp_valid,
  output logic signed [W-1:0] rsp_data,
  output logic [N-1:0]        rsp_last,
  output logic                busy,
  output logic                gen_start,
  output logic signed [W-1:0] gen_n,
  input  logic signed [W-1:0] gen_out0,
  input  logic                gen_valid,
  input  logic                gen_done
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;

  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_win;
  logic          w_any;
  logic [N-1:0]  w_win_oh;
  logic [N-1:0]  w_own_oh;

  // first requester at or after the pointer, searching cyclically
  always_comb begin
    w_idx = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % N);
      if (!w_any && req[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    w_win_oh[w_win] = 1'b1;
    w_own_oh = '0;
    w_own_oh[r_owner] = 1'b1;
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_last  <= '0;
      busy      <= 1'b0;
      gen_start <= 1'b0;
      gen_n     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant     <= w_win_oh;
            r_owner   <= w_win;
            gen_n     <= arg[w_win*W +: W];
            gen_start <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          gen_start <= 1'b0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          rsp_valid <= gen_valid ? w_own_oh : '0;
          if (gen_valid) begin
            rsp_data <= gen_out0;
          end
          if (gen_done) begin
            rsp_last <= w_own_oh;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          rsp_valid <= '0;
          rsp_last  <= '0;
          grant     <= '0;
          busy      <= 1'b0;
          r_ptr     <= (r_owner == PW'(N-1)) ? '0 : r_owner + PW'(1);
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generator_arbiter.sv
// tb_generator_arbiter: behavioural generator plus a timeline model of
// each run, derived from the arbitration and latency rules.
module tb_generator_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 3*N + 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N*W-1:0]      arg = '0;
  logic [N-1:0]        grant;
  logic [N-1:0]        rsp_valid;
  logic signed [W-1:0] rsp_data;
  logic [N-1:0]        rsp_last;
  logic                busy;
  logic                gen_start;
  logic signed [W-1:0] gen_n;
  logic signed [W-1:0] gen_out0;
  logic                gen_valid;
  logic                gen_done;
  logic                stray = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int argv [N];

  always #5 clk = ~clk;

  generator_arbiter #(.N(N), .W(W)) dut (
    ._clock   (clk),
    ._reset_n (rst_n),
    .req      (req),
    .arg      (arg),
    .grant    (grant),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .busy     (busy),
    .gen_start(gen_start),
    .gen_n    (gen_n),
    .gen_out0 (gen_out0),
    .gen_valid(gen_valid),
    .gen_done (gen_done)
  );

  // generator: after start with n, yields 0..n-1, done with the last word
  logic g_act;
  int   g_cnt;
  int   g_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_act <= 1'b0;
      g_cnt <= 0;
      g_n   <= 0;
    end else if (gen_start) begin
      g_act <= 1'b1;
      g_cnt <= 0;
      g_n   <= gen_n;
    end else if (g_act && (g_n == 0 || g_cnt == g_n - 1)) begin
      g_act <= 1'b0;
    end else if (g_act) begin
      g_cnt <= g_cnt + 1;
    end
  end

  assign gen_valid = (g_act && g_cnt < g_n) || stray;
  assign gen_done  = (g_act && (g_n == 0 || g_cnt == g_n - 1)) || stray;
  assign gen_out0  = g_cnt;

  function automatic logic [N-1:0] oh(int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic int pick(logic [N-1:0] r, int p);
    for (int o = 0; o < N; o++)
      if (r[(p + o) % N]) return (p + o) % N;
    return 0;
  endfunction

  task automatic set_arg(int i, int v);
    argv[i] = v;
    arg[i*W +: W] = W'(v);
  endtask

  // caller drives req so that w wins at the next rising edge
  task automatic check_run(int w, int n, bit st);
    int k;
    int ed;
    bit chk_d;
    logic [L-1:0] exp_c;
    logic [L-1:0] got_c;
    logic [N-1:0] eg, ev, el;
    k = (n == 0) ? 1 : n;
    if (st) stray = 1'b1;
    for (int i = 0; i <= k + 2; i++) begin
      @(negedge clk);
      if (i == 1) stray = 1'b0;
      eg = (i <= k + 1) ? oh(w) : '0;
      ev = (i >= 2 && i <= n + 1) ? oh(w) : '0;
      el = (i == k + 1) ? oh(w) : '0;
      exp_c = {eg, |eg, i == 0, ev, el};
      got_c = {grant, busy, gen_start, rsp_valid, rsp_last};
      chk_d = (n > 0 && i >= 2);
      ed = (i - 2 < n - 1) ? i - 2 : n - 1;
      n_tests++;
      if (got_c !== exp_c ||
          (chk_d && rsp_data !== W'(ed)) ||
          (i <= k + 1 && gen_n !== W'(n))) begin
        n_fail++;
        $display("FAIL run w=%0d n=%0d cyc=%0d: got ctl=%b data=%0d gen_n=%0d, want ctl=%b data=%0d gen_n=%0d",
                 w, n, i, got_c, rsp_data, gen_n, exp_c, ed, n);
      end
      if (i == k + 1) req[w] = 1'b0;
    end
    m_ptr = (w + 1) % N;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({grant, busy, gen_start, rsp_valid, rsp_last} !== '0 ||
        rsp_data !== '0 || gen_n !== '0) begin
      n_fail++;
      $display("FAIL reset: got ctl=%b data=%0d gen_n=%0d, want all 0",
               {grant, busy, gen_start, rsp_valid, rsp_last}, rsp_data, gen_n);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    n_tests++;
    if ({grant, busy, gen_start} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, want 0", {grant, busy, gen_start});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single();
    set_arg(0, 3);
    req = 4'b0001;
    check_run(0, 3, 1'b0);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b grant=%b, want 0 0", busy, grant);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_arg(i, int'($urandom_range(0, 5)));
    req = '1;
    for (int r = 0; r < 5; r++) begin
      check_run(order[r], argv[order[r]], 1'b0);
      req[order[r]] = 1'b1;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    set_arg(3, 2);
    set_arg(0, 1);
    req = 4'b1000;
    check_run(3, 2, 1'b0);
    req = 4'b1001;
    check_run(0, 1, 1'b0);
    req[0] = 1'b1;
    check_run(3, 2, 1'b0);
    check_run(0, 1, 1'b0);
  endtask

  task automatic test_zero_len();
    int w;
    set_arg(1, 0);
    set_arg(2, 2);
    req = 4'b0110;
    w = pick(req, m_ptr);
    check_run(w, argv[w], 1'b0);
    w = pick(req, m_ptr);
    check_run(w, argv[w], 1'b0);
  endtask

  task automatic test_stray();
    stray = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({grant, busy, gen_start, rsp_valid, rsp_last} !== '0) begin
        n_fail++;
        $display("FAIL stray_idle cyc=%0d: got %b, want 0", c,
                 {grant, busy, gen_start, rsp_valid, rsp_last});
      end
    end
    set_arg(0, 2);
    req = 4'b0001;
    check_run(0, 2, 1'b1);
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] nb;
    for (int r = 0; r < 20; r++) begin
      if (req == '0) begin
        w = int'($urandom_range(0, N - 1));
        set_arg(w, int'($urandom_range(0, 6)));
        req[w] = 1'b1;
      end
      w = pick(req, m_ptr);
      check_run(w, argv[w], 1'b0);
      nb = N'($urandom_range(0, (1 << N) - 1)) & ~req;
      for (int j = 0; j < N; j++) begin
        if (nb[j]) begin
          set_arg(j, int'($urandom_range(0, 6)));
          req[j] = 1'b1;
        end
      end
    end
    while (req != '0) begin
      w = pick(req, m_ptr);
      check_run(w, argv[w], 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    set_arg(1, 5);
    req = 4'b0010;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i == 3) begin
        n_tests++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 1) begin
          n_fail++;
          $display("FAIL mid_word1: got v=%b d=%0d, want v=0010 d=1",
                   rsp_valid, rsp_data);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({grant, busy, gen_start, rsp_valid, rsp_last} !== '0 ||
        rsp_data !== '0 || gen_n !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got ctl=%b data=%0d gen_n=%0d, want all 0",
               {grant, busy, gen_start, rsp_valid, rsp_last}, rsp_data, gen_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    check_run(1, 5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_zero_len();
    test_stray();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
